alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 125 ++++++++++++
 tb/tb_alu_exec_unit.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU with a bit-serial shifter, or a one-cycle barrel shifter
// when ALU_BARREL_SHIFT_EN is defined.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic             live_q;
    logic [3:0]       op_q, op_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             illegal_q, illegal_d;
    logic             accept, legal, long_shift;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res, step;

    // live_q keeps in_ready low until the first edge after reset release
    assign in_ready  = live_q && state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign accept    = in_valid && in_ready;
    assign shamt     = src_b[SW-1:0];

    always_comb begin
        legal   = 1'b1;
        alu_res = '0;
        case (alu_ctrl)
            4'b0000:         alu_res = src_a + src_b;
            4'b0001:         alu_res = src_a - src_b;
            4'b0010:         alu_res = src_a & src_b;
            4'b0011:         alu_res = src_a | src_b;
            4'b0101, 4'b1010: alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'b0100:         alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
            4'b0111:         alu_res = src_a ^ src_b;
`ifdef ALU_BARREL_SHIFT_EN
            4'b0110:         alu_res = src_a << shamt;
            4'b1000:         alu_res = src_a >> shamt;
            4'b1001:         alu_res = $unsigned($signed(src_a) >>> shamt);
`else
            // zero-amount shifts finish directly; others go through SHIFT
            4'b0110, 4'b1000, 4'b1001: alu_res = src_a;
`endif
            default:         legal = 1'b0;
        endcase
    end

`ifdef ALU_BARREL_SHIFT_EN
    assign long_shift = 1'b0;
`else
    assign long_shift = (alu_ctrl == 4'b0110 || alu_ctrl == 4'b1000 || alu_ctrl == 4'b1001)
                        && shamt != '0;
`endif

    assign step = op_q == 4'b0110 ? {result_q[WIDTH-2:0], 1'b0} :
                  op_q == 4'b1001 ? {result_q[WIDTH-1], result_q[WIDTH-1:1]} :
                                    {1'b0, result_q[WIDTH-1:1]};

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d   = long_shift ? SHIFT : DONE;
                op_d      = alu_ctrl;
                cnt_d     = long_shift ? shamt : '0;
                result_d  = long_shift ? src_a : alu_res;
                zero_d    = alu_res == '0;
                illegal_d = !legal;
            end
            SHIFT: begin
                result_d = step;
                cnt_d    = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    state_d = DONE;
                    zero_d  = step == '0;
                end
            end
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            live_q    <= 1'b0;
            op_q      <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            live_q    <= 1'b1;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed scoreboard bench for alu_exec_unit (WIDTH=32).
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_lat(input logic [3:0] c, input logic [31:0] b);
        int lat;
        lat = 1;
`ifndef ALU_BARREL_SHIFT_EN
        if ((c == 4'b0110 || c == 4'b1000 || c == 4'b1001) && b[4:0] != 5'd0)
            lat = int'(b[4:0]) + 1;
`endif
        return lat;
    endfunction

    // Called at a negedge with the unit idle.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] res, input logic ill,
                          input int hold);
        exp_t e;
        int   lat;
        logic [31:0] r0;
        e.res = res; e.z = (res == 32'd0); e.ill = ill; e.lat = exp_lat(c, b);
        sb.push_back(e);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; alu_ctrl = c; src_a = a; src_b = b;
        @(negedge clk);
        in_valid = 1'b0; alu_ctrl = 4'b0000; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_0003;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        check({tag, "_result"}, result, e.res);
        check({tag, "_zero"}, 32'(zero), 32'(e.z));
        check({tag, "_illegal"}, 32'(illegal), 32'(e.ill));
        check({tag, "_busy"}, 32'(in_ready), 32'd0);
        r0 = result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_result"}, result, r0);
            check({tag, "_hold_zero"}, 32'(zero), 32'(e.z));
            check({tag, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_release_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_release_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        alu_ctrl = 4'b0000; src_a = 32'd1; src_b = 32'd1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_release_ready", 32'(in_ready), 32'd0);
        @(negedge clk);

        run_op("add", 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0, 0);
        run_op("sub", 4'b0001, 32'h1234, 32'h1234, 32'd0, 1'b0, 0);
        run_op("sltu", 4'b0100, 32'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        run_op("slt", 4'b0101, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 0);
        run_op("slt_alt", 4'b1010, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 0);
        run_op("sra", 4'b1001, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 3);
        run_op("srl", 4'b1000, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 0);
        run_op("sra_pos", 4'b1001, 32'h4000_0000, 32'd3, 32'h0800_0000, 1'b0, 0);
        run_op("sll31", 4'b0110, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 0);
        run_op("sll0", 4'b0110, 32'h1234, 32'h0000_0100, 32'h1234, 1'b0, 0);
        run_op("and", 4'b0010, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 0);
        run_op("or", 4'b0011, 32'hF0F0, 32'hFF00, 32'hFFF0, 1'b0, 0);
        run_op("xor", 4'b0111, 32'hF0F0, 32'hFF00, 32'h0FF0, 1'b0, 0);
        run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 0);
        run_op("illegal", 4'b1111, 32'd9, 32'd9, 32'd0, 1'b1, 2);
        run_op("after_ill", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 0);

        in_valid = 1'b1; alu_ctrl = 4'b0110; src_a = 32'h0000_0001; src_b = 32'd20;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_zero", 32'(zero), 32'd0);
        check("abort_illegal", 32'(illegal), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            check("abort_never_valid", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        run_op("post_reset_add", 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
